fifo_port_arbiter: RTL and testbench
====================================

// Module: fifo_port_arbiter
// PURPOSE
//  Front-end scheduler for the 8-entry synchronous FIFO. Shares its single port among two write
//  requesters (W0, W1) and one read requester (R) using round-robin. Drives the FIFO's 3-bit
//  operation code plus registered write data, and keeps an occupancy count in lockstep with the
//  FIFO. Full writes and empty reads are completed as error acks, so requesters never hang.
// PARAMETERS
//  DATA_WIDTH  32  width of write data words
//  DEPTH       8   FIFO capacity in entries; must match the FIFO instance
//  CNT_WIDTH   4   occupancy counter width; must satisfy 2**CNT_WIDTH > DEPTH
// PORTS
//  clk         in   1           single clock, rising edge
//  reset       in   1           asynchronous reset, active-high
//  wr_req0     in   1           W0 request; level signal, held until wr_ack0
//  wr_din0     in   DATA_WIDTH  W0 data; stable while wr_req0=1
//  wr_req1     in   1           W1 request; level signal, held until wr_ack1
//  wr_din1     in   DATA_WIDTH  W1 data; stable while wr_req1=1
//  rd_req      in   1           R request; level signal, held until rd_ack
//  fifo_state  out  3           op code to FIFO: INIT/WRITE/WR_ERR/NO_OP/READ/RD_ERR
//  fifo_din    out  DATA_WIDTH  write data to FIFO; valid when fifo_state=WRITE
//  wr_ack0     out  1           1-cycle ack to W0
//  wr_ack1     out  1           1-cycle ack to W1
//  rd_ack      out  1           1-cycle ack to R
//  err         out  1           qualifies the acks in the same cycle; 1 = request dropped
//  data_count  out  CNT_WIDTH   occupancy after the op in fifo_state takes effect
// BEHAVIOUR
//  - Reset, and the 1st cycle after reset deasserts: fifo_state=INIT(000), fifo_din=0,
//    all acks=0, err=0, data_count=0, rr pointer=W0. Arbitration starts in the 2nd cycle.
//  - Reset asserted mid-operation: aborts at once; any pending request is re-arbitrated
//    after the INIT cycle. The INIT code also clears the FIFO pointers.
//  - All outputs are registered. A request sampled at edge N produces its op code and ack
//    together in cycle N+1, so latency is one cycle. One op per cycle, never a read and a write together.
//  - Masking: a requester whose ack is high this cycle is excluded from this cycle's
//    arbitration. This prevents a double grant while its request is still high.
//  - Round-robin order W0 -> W1 -> R. Search begins at the requester after the last grantee.
//    The pointer advances on every grant, including error grants.
//  - Grant outcomes (next cycle):
//    write granted, count<DEPTH: fifo_state=WRITE(001), fifo_din=granted data, ack, err=0, count+1
//    write granted, count=DEPTH: fifo_state=WR_ERR(010), ack, err=1, count held, data dropped
//    read granted, count>0:      fifo_state=READ(100), rd_ack, err=0, count-1
//    read granted, count=0:      fifo_state=RD_ERR(101), rd_ack, err=1, count held
//    no eligible request:        fifo_state=NO_OP(011), no ack, count held
//  - Count arithmetic is unsigned CNT_WIDTH. It never exceeds DEPTH or wraps below 0.
//    fifo_din holds its last value outside WRITE cycles.
//  - Full boundary: W0 and W1 both pending at count=DEPTH-1. The first grantee gets WRITE and
//    count becomes DEPTH. The second grantee gets WR_ERR unless R is granted between them.
//  - Back-to-back: a requester holding its request after an ack is eligible again in the
//    cycle after the ack. With all three requesters held high, grants cycle W0, W1, R, W0...
// STRUCTURE
//  - Shared package fifo_pkg: op codes INIT=000, WRITE=001, WR_ERR=010, NO_OP=011,
//    READ=100, RD_ERR=101, and FIFO_SIZE=8. The FIFO datapath uses the same package.
//  - Sub-module rr_arbiter3: combinational 3-way round-robin. Inputs are the masked requests
//    and the last-grant pointer; output is a one-hot grant. Requester ids are package constants.
//  - Top level holds the registered op code, acks, err, fifo_din, pointer and count, with
//    compare logic against DEPTH and 0.
// TESTING
//  1. Reset, release, no requests -> INIT for 1 cycle, then NO_OP every cycle, count=0.
//  2. W0 writes 0xA5A5_0001 -> next cycle fifo_state=001, fifo_din=0xA5A5_0001,
//     wr_ack0=1, err=0, count=1.
//  3. Hold wr_req0, wr_req1, rd_req high from count=3 -> grants W0, W1, R, W0 in that order,
//     with count 4, 5, 4, 5. There is no double grant.
//  4. W1 writes 9 times from empty -> 8 WRITE grants with count reaching 8, then the 9th
//     gives fifo_state=010, wr_ack1=1, err=1, count=8.
//  5. R reads at count=0 -> fifo_state=101, rd_ack=1, err=1, count stays 0.
//  6. Reset asserted while W0 is pending at count=5 -> outputs clear asynchronously, count=0.
//     After release: INIT, then W0 is granted WRITE and count=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO and its port arbiter:
// op codes presented on the FIFO port and requester ids.
package fifo_pkg;

    localparam int FIFO_SIZE = 8;

    typedef enum logic [2:0] {
        OP_INIT   = 3'b000,
        OP_WRITE  = 3'b001,
        OP_WR_ERR = 3'b010,
        OP_NO_OP  = 3'b011,
        OP_READ   = 3'b100,
        OP_RD_ERR = 3'b101
    } op_e;

    typedef logic [1:0] rid_t;

    localparam rid_t ID_W0 = 2'd0;
    localparam rid_t ID_W1 = 2'd1;
    localparam rid_t ID_R  = 2'd2;

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin; the search starts at the
// requester after the last grantee, order W0 -> W1 -> R.
module rr_arbiter3
    import fifo_pkg::*;
(
    input  logic [2:0] req,
    input  rid_t       last,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        unique case (last)
            ID_W0: begin
                if (req[ID_W1])      gnt[ID_W1] = 1'b1;
                else if (req[ID_R])  gnt[ID_R]  = 1'b1;
                else if (req[ID_W0]) gnt[ID_W0] = 1'b1;
            end
            ID_W1: begin
                if (req[ID_R])       gnt[ID_R]  = 1'b1;
                else if (req[ID_W0]) gnt[ID_W0] = 1'b1;
                else if (req[ID_W1]) gnt[ID_W1] = 1'b1;
            end
            default: begin
                if (req[ID_W0])      gnt[ID_W0] = 1'b1;
                else if (req[ID_W1]) gnt[ID_W1] = 1'b1;
                else if (req[ID_R])  gnt[ID_R]  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Schedules two writers and one reader onto the single FIFO port
// and tracks occupancy in lockstep with the FIFO.
module fifo_port_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = FIFO_SIZE,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req0,
    input  logic [DATA_WIDTH-1:0] wr_din0,
    input  logic                  wr_req1,
    input  logic [DATA_WIDTH-1:0] wr_din1,
    input  logic                  rd_req,
    output logic [2:0]            fifo_state,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  wr_ack0,
    output logic                  wr_ack1,
    output logic                  rd_ack,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  data_count
);

    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

    op_e                   op_q, op_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  ack0_q, ack1_q, rack_q, err_q;
    logic                  ack0_d, ack1_d, rack_d, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    rid_t                  last_q, last_d;
    logic                  run_q;
    logic [2:0]            req_m, gnt;
    logic                  wr_g;
    logic [DATA_WIDTH-1:0] wdata;

    // A requester being acked now still has its level request up.
    assign req_m = {rd_req  & ~rack_q,
                    wr_req1 & ~ack1_q,
                    wr_req0 & ~ack0_q} & {3{run_q}};

    rr_arbiter3 u_rr (
        .req  (req_m),
        .last (last_q),
        .gnt  (gnt)
    );

    assign wr_g  = gnt[ID_W0] | gnt[ID_W1];
    assign wdata = gnt[ID_W1] ? wr_din1 : wr_din0;

    always_comb begin
        op_d   = run_q ? OP_NO_OP : OP_INIT;
        din_d  = din_q;
        ack0_d = gnt[ID_W0];
        ack1_d = gnt[ID_W1];
        rack_d = gnt[ID_R];
        err_d  = 1'b0;
        cnt_d  = cnt_q;
        last_d = last_q;
        unique case (1'b1)
            gnt[ID_W0]: last_d = ID_W0;
            gnt[ID_W1]: last_d = ID_W1;
            gnt[ID_R]:  last_d = ID_R;
            default:    ;
        endcase
        if (wr_g) begin
            if (cnt_q == FULL) begin
                op_d  = OP_WR_ERR;
                err_d = 1'b1;
            end else begin
                op_d  = OP_WRITE;
                din_d = wdata;
                cnt_d = cnt_q + 1'b1;
            end
        end else if (gnt[ID_R]) begin
            if (cnt_q == '0) begin
                op_d  = OP_RD_ERR;
                err_d = 1'b1;
            end else begin
                op_d  = OP_READ;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // run_q holds off arbitration for the INIT cycle after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= OP_INIT;
            din_q  <= '0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            rack_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            last_q <= ID_W0;
            run_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            din_q  <= din_d;
            ack0_q <= ack0_d;
            ack1_q <= ack1_d;
            rack_q <= rack_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            run_q  <= 1'b1;
        end
    end

    assign fifo_state = op_q;
    assign fifo_din   = din_q;
    assign wr_ack0    = ack0_q;
    assign wr_ack1    = ack1_q;
    assign rd_ack     = rack_q;
    assign err        = err_q;
    assign data_count = cnt_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Scoreboard bench for fifo_port_arbiter: requester drivers,
// expected-response queue and an ack-driven monitor.
module tb_fifo_port_arbiter;
    import fifo_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  acks;
        logic        err;
        logic [31:0] din;
        logic [3:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_req0 = 1'b0;
    logic [31:0] wr_din0 = '0;
    logic        wr_req1 = 1'b0;
    logic [31:0] wr_din1 = '0;
    logic        rd_req = 1'b0;
    logic [2:0]  fifo_state;
    logic [31:0] fifo_din;
    logic        wr_ack0, wr_ack1, rd_ack, err;
    logic [3:0]  data_count;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          nr = 0;

    fifo_port_arbiter #(
        .DATA_WIDTH (32),
        .DEPTH      (8),
        .CNT_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req0    (wr_req0),
        .wr_din0    (wr_din0),
        .wr_req1    (wr_req1),
        .wr_din1    (wr_din1),
        .rd_req     (rd_req),
        .fifo_state (fifo_state),
        .fifo_din   (fifo_din),
        .wr_ack0    (wr_ack0),
        .wr_ack1    (wr_ack1),
        .rd_ack     (rd_ack),
        .err        (err),
        .data_count (data_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [2:0] acks,
                        input logic e, input logic [31:0] d,
                        input logic [3:0] c);
        exp_t x;
        x.op = op; x.acks = acks; x.err = e; x.din = d; x.cnt = c;
        exp_q.push_back(x);
    endtask

    // Requesters hold their level request until acked, then present the next item.
    always @(negedge clk) begin
        if (wr_ack0) wr_req0 = 1'b0;
        if (!wr_req0 && q0.size() > 0) begin
            wr_din0 = q0.pop_front();
            wr_req0 = 1'b1;
        end
        if (wr_ack1) wr_req1 = 1'b0;
        if (!wr_req1 && q1.size() > 0) begin
            wr_din1 = q1.pop_front();
            wr_req1 = 1'b1;
        end
        if (rd_ack) rd_req = 1'b0;
        if (!rd_req && nr > 0) begin
            nr--;
            rd_req = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [2:0] acks;
        exp_t       e;
        if (!reset) begin
            acks = {rd_ack, wr_ack1, wr_ack0};
            if (acks != 3'b000) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: acks=%b state=%b",
                             acks, fifo_state);
                end else begin
                    e = exp_q.pop_front();
                    chk("op", 32'(fifo_state), 32'(e.op));
                    chk("acks", 32'(acks), 32'(e.acks));
                    chk("err", 32'(err), 32'(e.err));
                    chk("count", 32'(data_count), 32'(e.cnt));
                    if (e.op == OP_WRITE)
                        chk("din", fifo_din, e.din);
                end
            end else begin
                chk("idle_op",
                    32'(fifo_state == OP_NO_OP || fifo_state == OP_INIT),
                    32'd1);
                chk("idle_err", 32'(err), 32'd0);
            end
        end
    end

    task automatic drain(input logic [3:0] c);
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            #2;
            done = exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0
                   && nr == 0 && !wr_req0 && !wr_req1 && !rd_req;
        end
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses still pending",
                     exp_q.size());
            exp_q.delete();
        end
        checks++;
        @(negedge clk);
        chk("rest_op", 32'(fifo_state), 32'(OP_NO_OP));
        chk("rest_count", 32'(data_count), 32'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        // 1: reset, release, idle
        repeat (2) @(negedge clk);
        chk("rst_op", 32'(fifo_state), 32'(OP_INIT));
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_acks", 32'({rd_ack, wr_ack1, wr_ack0, err}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("init_cycle", 32'(fifo_state), 32'(OP_INIT));
        @(negedge clk);
        chk("first_noop", 32'(fifo_state), 32'(OP_NO_OP));
        @(negedge clk);
        chk("idle_count", 32'(data_count), 32'd0);

        // 2: single W0 write
        @(posedge clk); #2;
        push(OP_WRITE, 3'b001, 1'b0, 32'hA5A5_0001, 4'd1);
        q0.push_back(32'hA5A5_0001);
        drain(4'd1);

        // bring count to 3 with R as last grantee
        @(posedge clk); #2;
        push(OP_WRITE, 3'b001, 1'b0, 32'h11, 4'd2);
        push(OP_WRITE, 3'b001, 1'b0, 32'h12, 4'd3);
        push(OP_WRITE, 3'b001, 1'b0, 32'h13, 4'd4);
        q0.push_back(32'h11);
        q0.push_back(32'h12);
        q0.push_back(32'h13);
        drain(4'd4);
        @(posedge clk); #2;
        push(OP_READ, 3'b100, 1'b0, 32'h0, 4'd3);
        nr = 1;
        drain(4'd3);

        // 3: all three held high
        @(posedge clk); #2;
        push(OP_WRITE, 3'b001, 1'b0, 32'h30, 4'd4);
        push(OP_WRITE, 3'b010, 1'b0, 32'h31, 4'd5);
        push(OP_READ,  3'b100, 1'b0, 32'h0,  4'd4);
        push(OP_WRITE, 3'b001, 1'b0, 32'h32, 4'd5);
        q0.push_back(32'h30);
        q0.push_back(32'h32);
        q1.push_back(32'h31);
        nr = 1;
        drain(4'd5);

        // empty it, then 5: read at count 0
        @(posedge clk); #2;
        for (int i = 4; i >= 0; i--)
            push(OP_READ, 3'b100, 1'b0, 32'h0, 4'(i));
        nr = 5;
        drain(4'd0);
        @(posedge clk); #2;
        push(OP_RD_ERR, 3'b100, 1'b1, 32'h0, 4'd0);
        nr = 1;
        drain(4'd0);

        // 4: W1 writes 9 times from empty
        @(posedge clk); #2;
        for (int i = 0; i < 8; i++) begin
            push(OP_WRITE, 3'b010, 1'b0, 32'h40 + 32'(i), 4'(i + 1));
            q1.push_back(32'h40 + 32'(i));
        end
        push(OP_WR_ERR, 3'b010, 1'b1, 32'h0, 4'd8);
        q1.push_back(32'h48);
        drain(4'd8);
        chk("din_hold_err", fifo_din, 32'h47);

        // full boundary: both writers pending at DEPTH-1
        @(posedge clk); #2;
        push(OP_READ, 3'b100, 1'b0, 32'h0, 4'd7);
        nr = 1;
        drain(4'd7);
        @(posedge clk); #2;
        push(OP_WRITE,  3'b001, 1'b0, 32'h50, 4'd8);
        push(OP_WR_ERR, 3'b010, 1'b1, 32'h0,  4'd8);
        q0.push_back(32'h50);
        q1.push_back(32'h51);
        drain(4'd8);
        chk("din_hold_full", fifo_din, 32'h50);
        @(posedge clk); #2;
        push(OP_READ, 3'b100, 1'b0, 32'h0, 4'd7);
        push(OP_READ, 3'b100, 1'b0, 32'h0, 4'd6);
        push(OP_READ, 3'b100, 1'b0, 32'h0, 4'd5);
        nr = 3;
        drain(4'd5);

        // 6: reset while W0 pending at count 5
        @(posedge clk); #2;
        push(OP_WRITE, 3'b001, 1'b0, 32'h60, 4'd1);
        q0.push_back(32'h60);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("async_op", 32'(fifo_state), 32'(OP_INIT));
        chk("async_count", 32'(data_count), 32'd0);
        chk("async_din", fifo_din, 32'd0);
        chk("async_acks", 32'({rd_ack, wr_ack1, wr_ack0, err}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reinit_cycle", 32'(fifo_state), 32'(OP_INIT));
        drain(4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
